isdu_ws: RTL and testbench

- Parametrised LC-3 instruction-sequencing/decode unit; successor to the fixed two-cycle-read ISDU.
- Drives all datapath load/gate/mux controls and SRAM strobes for the full lab subset: ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR, PAUSE.
- Adds a configurable SRAM access time for both read and write, an optional post-fetch IR pause, and a debug state output.

---
 rtl/isdu_pkg.sv | 98 +++++++++
 rtl/isdu_wait_cnt.sv | 34 +++
 rtl/isdu_ws.sv | 225 ++++++++++++++++++++++
 tb/tb_isdu_ws.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
// isdu_pkg: shared state encoding, opcode values and mux encodings for the LC-3 sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: state_t (5-bit, also driven out as the debug state), OP_* opcode values,
// PCMUX/ADDR2MUX/ALUK/DRMUX/SR1MUX encodings, decode and access-state helpers.
package isdu_pkg;

    // Encodings of S00..S27 match their state numbers where they fit in 5 bits.
    // The remaining states take otherwise unused codes.
    typedef enum logic [4:0] {
        ST_S00       = 5'd0,
        ST_S01       = 5'd1,
        ST_HALTED    = 5'd2,
        ST_PAUSE_IR1 = 5'd3,
        ST_S04       = 5'd4,
        ST_S05       = 5'd5,
        ST_S06       = 5'd6,
        ST_S07       = 5'd7,
        ST_PAUSE_IR2 = 5'd8,
        ST_S09       = 5'd9,
        ST_PAUSE1    = 5'd10,
        ST_PAUSE2    = 5'd11,
        ST_S12       = 5'd12,
        ST_S32       = 5'd13,
        ST_S33       = 5'd14,
        ST_S35       = 5'd15,
        ST_S16       = 5'd16,
        ST_S18       = 5'd18,
        ST_S20       = 5'd20,
        ST_S21       = 5'd21,
        ST_S22       = 5'd22,
        ST_S23       = 5'd23,
        ST_S25       = 5'd25,
        ST_S27       = 5'd27
    } state_t;

    // IR[15:12] opcode values
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    // PC input select
    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    // Address adder second operand
    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // Address adder first operand
    localparam logic ADDR1_PC  = 1'b0;
    localparam logic ADDR1_SR1 = 1'b1;

    // ALU function
    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // Destination register select
    localparam logic [1:0] DRMUX_IR11_9 = 2'b00;
    localparam logic [1:0] DRMUX_R7     = 2'b01;

    // SR1 select
    localparam logic [1:0] SR1MUX_IR11_9 = 2'b00;
    localparam logic [1:0] SR1MUX_IR8_6  = 2'b01;

    // Dispatch target out of S32. Unsupported opcodes go straight back to fetch.
    function automatic state_t decode_opcode(input logic [3:0] op);
        case (op)
            OP_ADD:   return ST_S01;
            OP_AND:   return ST_S05;
            OP_NOT:   return ST_S09;
            OP_BR:    return ST_S00;
            OP_JMP:   return ST_S12;
            OP_JSR:   return ST_S04;
            OP_LDR:   return ST_S06;
            OP_STR:   return ST_S07;
            OP_PAUSE: return ST_PAUSE1;
            default:  return ST_S18;
        endcase
    endfunction

    // States that hold an SRAM strobe for MEM_WAIT+1 cycles.
    function automatic logic is_access(input state_t s);
        return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
    endfunction

endpackage

// File: rtl/isdu_wait_cnt.sv
// isdu_wait_cnt: counts the cycles spent in an SRAM access state and flags the last one.
// Latency: o_done is combinational from the count; the count updates one cycle after i_en.
// Backpressure: none; the FSM stays in the access state until o_done.
// Ports: i_clk clock, i_rst synchronous active-high reset, i_clr zero the count,
//        i_en advance while in an access state, o_done count has reached MEM_WAIT.
module isdu_wait_cnt #(
    parameter int MEM_WAIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam logic [3:0] LP_LAST = 4'(MEM_WAIT);

    logic [3:0] r_cnt;

    // The count only advances up to LP_LAST; the FSM leaves the access state
    // on that cycle, after which i_clr zeroes it for the next access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en && !o_done) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_done = (r_cnt == LP_LAST);

endmodule

// File: rtl/isdu_ws.sv
// isdu_ws: LC-3 instruction sequencing/decode unit driving datapath loads, gates, muxes and SRAM strobes.
// Latency: Moore outputs from the state register; each SRAM access lasts MEM_WAIT+1 cycles.
// Backpressure: waits on Run in Halted, on ContinueIR in the IR pause and on Continue for PAUSE.
// Ports: Clk, Reset (sync, active-high); Run/Continue/ContinueIR handshakes; Opcode, IR_5, IR_11, BEN from the datapath;
//        LD_* register loads, Gate* bus drivers, *MUX selects, ALUK; Mem_* active-low SRAM strobes; State_o debug state.
module isdu_ws
    import isdu_pkg::*;
#(
    parameter int MEM_WAIT    = 1,
    parameter int PAUSE_IR_EN = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic       ContinueIR,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic       MARMUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] State_o
);

    state_t r_state;
    logic   w_in_access;
    logic   w_wait_clr;
    logic   w_wait_done;

    assign w_in_access = is_access(r_state);
    assign w_wait_clr  = !w_in_access;

    // One counter serves S33, S25 and S16; it sits at zero outside them, so
    // every access starts counting from zero.
    isdu_wait_cnt #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait_cnt (
        .i_clk (Clk),
        .i_rst (Reset),
        .i_clr (w_wait_clr),
        .i_en  (w_in_access),
        .o_done(w_wait_done)
    );

    // ------------------------------------------------------------------
    // State register and transitions
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_HALTED;
        end else begin
            case (r_state)
                ST_HALTED:    if (Run) r_state <= ST_S18;
                ST_S18:       r_state <= ST_S33;
                ST_S33:       if (w_wait_done) r_state <= ST_S35;
                ST_S35:       r_state <= (PAUSE_IR_EN != 0) ? ST_PAUSE_IR1 : ST_S32;
                ST_PAUSE_IR1: if (ContinueIR) r_state <= ST_PAUSE_IR2;
                ST_PAUSE_IR2: if (!ContinueIR) r_state <= ST_S32;
                ST_S32:       r_state <= decode_opcode(Opcode);
                ST_S01,
                ST_S05,
                ST_S09:       r_state <= ST_S18;
                ST_S00:       r_state <= BEN ? ST_S22 : ST_S18;
                ST_S22:       r_state <= ST_S18;
                ST_S12:       r_state <= ST_S18;
                // S04 has already written the return PC into R7, so the PC
                // update in S21/S20 cannot disturb it.
                ST_S04:       r_state <= IR_11 ? ST_S21 : ST_S20;
                ST_S21,
                ST_S20:       r_state <= ST_S18;
                ST_S06:       r_state <= ST_S25;
                ST_S25:       if (w_wait_done) r_state <= ST_S27;
                ST_S27:       r_state <= ST_S18;
                ST_S07:       r_state <= ST_S23;
                ST_S23:       r_state <= ST_S16;
                ST_S16:       if (w_wait_done) r_state <= ST_S18;
                ST_PAUSE1:    if (Continue) r_state <= ST_PAUSE2;
                ST_PAUSE2:    if (!Continue) r_state <= ST_S18;
                default:      r_state <= ST_HALTED;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control decode. Everything depends on the state alone, apart from
    // SR2MUX following IR_5 in the two-operand ALU states and LD_MDR
    // waiting for the last cycle of a read.
    // ------------------------------------------------------------------
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        DRMUX      = DRMUX_IR11_9;
        SR1MUX     = SR1MUX_IR11_9;
        SR2MUX     = 1'b0;
        ADDR1MUX   = ADDR1_PC;
        ADDR2MUX   = ADDR2_ZERO;
        MARMUX     = 1'b0;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        case (r_state)
            ST_S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = PCMUX_PC1;
            end
            ST_S33, ST_S25: begin
                Mem_OE = 1'b0;
                LD_MDR = w_wait_done;
            end
            ST_S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            ST_S32: begin
                LD_BEN = 1'b1;
            end
            ST_S01, ST_S05, ST_S09: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR1MUX  = SR1MUX_IR8_6;
                if (r_state == ST_S09) begin
                    ALUK = ALUK_NOT;
                end else begin
                    ALUK   = (r_state == ST_S05) ? ALUK_AND : ALUK_ADD;
                    SR2MUX = IR_5;
                end
            end
            ST_S22: begin
                ADDR1MUX = ADDR1_PC;
                ADDR2MUX = ADDR2_OFF9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            // JMP and JSRR both load PC from the base register.
            ST_S12, ST_S20: begin
                SR1MUX   = SR1MUX_IR8_6;
                ADDR1MUX = ADDR1_SR1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            ST_S04: begin
                GatePC = 1'b1;
                DRMUX  = DRMUX_R7;
                LD_REG = 1'b1;
            end
            ST_S21: begin
                ADDR1MUX = ADDR1_PC;
                ADDR2MUX = ADDR2_OFF11;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            // LDR and STR share the base+offset6 address computation.
            ST_S06, ST_S07: begin
                SR1MUX     = SR1MUX_IR8_6;
                ADDR1MUX   = ADDR1_SR1;
                ADDR2MUX   = ADDR2_OFF6;
                MARMUX     = 1'b1;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            ST_S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            // Store data is SR (IR[11:9]) passed through the ALU.
            ST_S23: begin
                SR1MUX  = SR1MUX_IR11_9;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            // Write strobe only; Mem_OE keeps its inactive default.
            ST_S16: begin
                Mem_WE = 1'b0;
            end
            default: ;
        endcase
    end

    // Chip and byte enables are permanently active.
    assign Mem_CE  = 1'b0;
    assign Mem_UB  = 1'b0;
    assign Mem_LB  = 1'b0;
    assign State_o = r_state;

endmodule

// File: tb/tb_isdu_ws.sv
// tb_isdu_ws: scoreboard bench for isdu_ws over four MEM_WAIT/PAUSE_IR_EN configurations.
// Latency: expected control words are queued per instruction and checked one per clock.
// Backpressure: handshake inputs are driven on the cycles the instruction model calls for.
module tb_isdu_ws;
    import isdu_pkg::*;

    localparam int NI = 4;

    typedef struct packed {
        logic [4:0] st;
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, drmux, sr1mux;
        logic       sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic       marmux;
        logic [1:0] aluk;
        logic       ce, ub, lb, oe, we;
    } ctrl_t;

    typedef struct packed {
        logic rst, run, cont, contir;
    } drv_t;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_p(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    logic       Clk;
    int         checks;
    int         failures;
    logic       rst_a    [NI];
    logic       run_a    [NI];
    logic       cont_a   [NI];
    logic       contir_a [NI];
    logic       ir5_a    [NI];
    logic       ir11_a   [NI];
    logic       ben_a    [NI];
    logic [3:0] op_a     [NI];
    ctrl_t      act      [NI];
    ctrl_t      exp_q    [NI][$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, drmux, sr1mux, addr2mux, aluk;
        logic       sr2mux, addr1mux, marmux;
        logic       ce, ub, lb, oe, we;
        logic [4:0] st;

        isdu_ws #(
            .MEM_WAIT   (cfg_w(g)),
            .PAUSE_IR_EN(cfg_p(g))
        ) u_dut (
            .Clk       (Clk),
            .Reset     (rst_a[g]),
            .Run       (run_a[g]),
            .Continue  (cont_a[g]),
            .ContinueIR(contir_a[g]),
            .Opcode    (op_a[g]),
            .IR_5      (ir5_a[g]),
            .IR_11     (ir11_a[g]),
            .BEN       (ben_a[g]),
            .LD_MAR    (ld_mar),
            .LD_MDR    (ld_mdr),
            .LD_IR     (ld_ir),
            .LD_BEN    (ld_ben),
            .LD_CC     (ld_cc),
            .LD_REG    (ld_reg),
            .LD_PC     (ld_pc),
            .GatePC    (gate_pc),
            .GateMDR   (gate_mdr),
            .GateALU   (gate_alu),
            .GateMARMUX(gate_marmux),
            .PCMUX     (pcmux),
            .DRMUX     (drmux),
            .SR1MUX    (sr1mux),
            .SR2MUX    (sr2mux),
            .ADDR1MUX  (addr1mux),
            .ADDR2MUX  (addr2mux),
            .MARMUX    (marmux),
            .ALUK      (aluk),
            .Mem_CE    (ce),
            .Mem_UB    (ub),
            .Mem_LB    (lb),
            .Mem_OE    (oe),
            .Mem_WE    (we),
            .State_o   (st)
        );

        assign act[g] = {st, ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc,
                         gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, drmux, sr1mux,
                         sr2mux, addr1mux, addr2mux, marmux, aluk, ce, ub, lb, oe, we};
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Control word the unit must present while sitting in state s.
    function automatic ctrl_t exp_word(input state_t s, input logic ir5, input logic last);
        ctrl_t w;
        w    = '0;
        w.st = s;
        w.oe = 1'b1;
        w.we = 1'b1;
        case (s)
            ST_S18: begin w.gate_pc = 1; w.ld_mar = 1; w.ld_pc = 1; end
            ST_S33, ST_S25: begin w.oe = 0; w.ld_mdr = last; end
            ST_S35: begin w.gate_mdr = 1; w.ld_ir = 1; end
            ST_S32: w.ld_ben = 1;
            ST_S01: begin w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1; w.sr1mux = 2'b01; w.aluk = 2'b00; w.sr2mux = ir5; end
            ST_S05: begin w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1; w.sr1mux = 2'b01; w.aluk = 2'b01; w.sr2mux = ir5; end
            ST_S09: begin w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1; w.sr1mux = 2'b01; w.aluk = 2'b10; end
            ST_S22: begin w.addr2mux = 2'b10; w.pcmux = 2'b10; w.ld_pc = 1; end
            ST_S12, ST_S20: begin w.sr1mux = 2'b01; w.addr1mux = 1; w.pcmux = 2'b10; w.ld_pc = 1; end
            ST_S04: begin w.gate_pc = 1; w.drmux = 2'b01; w.ld_reg = 1; end
            ST_S21: begin w.addr2mux = 2'b11; w.pcmux = 2'b10; w.ld_pc = 1; end
            ST_S06, ST_S07: begin w.sr1mux = 2'b01; w.addr1mux = 1; w.addr2mux = 2'b01; w.marmux = 1; w.gate_marmux = 1; w.ld_mar = 1; end
            ST_S27: begin w.gate_mdr = 1; w.ld_reg = 1; w.ld_cc = 1; end
            ST_S23: begin w.aluk = 2'b11; w.gate_alu = 1; w.ld_mdr = 1; end
            ST_S16: w.we = 0;
            default: ;
        endcase
        return w;
    endfunction

    function automatic drv_t dv(input logic rst, input logic run, input logic cont, input logic contir);
        drv_t d;
        d.rst    = rst;
        d.run    = run;
        d.cont   = cont;
        d.contir = contir;
        return d;
    endfunction

    // Monitor: one expected word per clock per configuration, sampled mid-cycle.
    always @(negedge Clk) begin
        ctrl_t e;
        for (int i = 0; i < NI; i++) begin
            if (exp_q[i].size() > 0) begin
                e = exp_q[i].pop_front();
                checks++;
                if (act[i] !== e) begin
                    failures++;
                    $display("FAIL ctrl_word cfg%0d t=%0t: got state=%0d word=%h, expected state=%0d word=%h",
                             i, $time, act[i].st, act[i], e.st, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Queue the expected words, then drive one input set per clock.
    task automatic run_slots(input int id, input ctrl_t ws[$], input drv_t ds[$]);
        foreach (ws[j]) exp_q[id].push_back(ws[j]);
        foreach (ds[j]) begin
            rst_a[id]    = ds[j].rst;
            run_a[id]    = ds[j].run;
            cont_a[id]   = ds[j].cont;
            contir_a[id] = ds[j].contir;
            tick();
        end
    endtask

    task automatic start(input int id);
        ctrl_t ws[$];
        drv_t  ds[$];
        rst_a[id] = 1; run_a[id] = 0; cont_a[id] = 0; contir_a[id] = 0;
        op_a[id] = 4'd0; ir5_a[id] = 0; ir11_a[id] = 0; ben_a[id] = 0;
        tick();
        tick();
        ws.push_back(exp_word(ST_HALTED, 0, 0)); ds.push_back(dv(0, 0, 0, 0));
        ws.push_back(exp_word(ST_HALTED, 0, 0)); ds.push_back(dv(0, 1, 0, 0));
        run_slots(id, ws, ds);
    endtask

    // One instruction from its S18 fetch cycle up to the next S18.
    // rst_at >= 0 pulses Reset during that cycle of an LDR read, then restarts with Run.
    task automatic issue(input int id, input logic [3:0] op, input logic ir5, input logic ir11,
                         input logic ben, input int h1, input int h2, input int rst_at);
        ctrl_t ws[$];
        drv_t  ds[$];
        int    w;
        int    ih1;
        int    ih2;
        bit    was_reset;
        w         = cfg_w(id);
        ih1       = $urandom_range(1, 3);
        ih2       = $urandom_range(1, 3);
        was_reset = 0;
        op_a[id] = op; ir5_a[id] = ir5; ir11_a[id] = ir11; ben_a[id] = ben;

        ws.push_back(exp_word(ST_S18, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
        for (int k = 0; k <= w; k++) begin
            ws.push_back(exp_word(ST_S33, ir5, k == w)); ds.push_back(dv(0, 0, 0, 0));
        end
        ws.push_back(exp_word(ST_S35, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
        if (cfg_p(id) != 0) begin
            for (int k = 0; k < ih1; k++) begin
                ws.push_back(exp_word(ST_PAUSE_IR1, ir5, 0)); ds.push_back(dv(0, 0, 0, k == ih1 - 1));
            end
            for (int k = 0; k < ih2; k++) begin
                ws.push_back(exp_word(ST_PAUSE_IR2, ir5, 0)); ds.push_back(dv(0, 0, 0, k < ih2 - 1));
            end
        end
        ws.push_back(exp_word(ST_S32, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));

        case (op)
            4'b0001: begin ws.push_back(exp_word(ST_S01, ir5, 0)); ds.push_back(dv(0, 0, 0, 0)); end
            4'b0101: begin ws.push_back(exp_word(ST_S05, ir5, 0)); ds.push_back(dv(0, 0, 0, 0)); end
            4'b1001: begin ws.push_back(exp_word(ST_S09, ir5, 0)); ds.push_back(dv(0, 0, 0, 0)); end
            4'b1100: begin ws.push_back(exp_word(ST_S12, ir5, 0)); ds.push_back(dv(0, 0, 0, 0)); end
            4'b0000: begin
                ws.push_back(exp_word(ST_S00, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                if (ben) begin ws.push_back(exp_word(ST_S22, ir5, 0)); ds.push_back(dv(0, 0, 0, 0)); end
            end
            4'b0100: begin
                ws.push_back(exp_word(ST_S04, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                ws.push_back(exp_word(ir11 ? ST_S21 : ST_S20, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
            end
            4'b0110: begin
                ws.push_back(exp_word(ST_S06, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                for (int k = 0; k <= w; k++) begin
                    ws.push_back(exp_word(ST_S25, ir5, k == w)); ds.push_back(dv(k == rst_at, 0, 0, 0));
                    if (k == rst_at) begin
                        was_reset = 1;
                        break;
                    end
                end
                if (was_reset) begin
                    ws.push_back(exp_word(ST_HALTED, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                    ws.push_back(exp_word(ST_HALTED, ir5, 0)); ds.push_back(dv(0, 1, 0, 0));
                end else begin
                    ws.push_back(exp_word(ST_S27, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                end
            end
            4'b0111: begin
                ws.push_back(exp_word(ST_S07, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                ws.push_back(exp_word(ST_S23, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                for (int k = 0; k <= w; k++) begin
                    ws.push_back(exp_word(ST_S16, ir5, 0)); ds.push_back(dv(0, 0, 0, 0));
                end
            end
            4'b1101: begin
                for (int k = 0; k < h1; k++) begin
                    ws.push_back(exp_word(ST_PAUSE1, ir5, 0)); ds.push_back(dv(0, 0, k == h1 - 1, 0));
                end
                for (int k = 0; k < h2; k++) begin
                    ws.push_back(exp_word(ST_PAUSE2, ir5, 0)); ds.push_back(dv(0, 0, k < h2 - 1, 0));
                end
            end
            default: ;
        endcase
        run_slots(id, ws, ds);
    endtask

    task automatic play(input int id);
        int         w;
        logic [3:0] op;
        int         ra;
        w = cfg_w(id);
        start(id);
        issue(id, 4'b0001, 1'b1, 0, 0, 1, 1, -1);   // ADD, immediate form
        issue(id, 4'b0000, 1'b0, 0, 1, 1, 1, -1);   // BR taken
        issue(id, 4'b0000, 1'b0, 0, 0, 1, 1, -1);   // BR not taken
        issue(id, 4'b0111, 1'b0, 0, 0, 1, 1, -1);   // STR
        issue(id, 4'b0100, 1'b0, 1, 0, 1, 1, -1);   // JSR
        issue(id, 4'b0100, 1'b0, 0, 0, 1, 1, -1);   // JSRR
        issue(id, 4'b1101, 1'b0, 0, 0, 11, 2, -1);  // PAUSE: 10 idle cycles, Continue high 2 cycles
        issue(id, 4'b0110, 1'b0, 0, 0, 1, 1, (w >= 1) ? 1 : 0); // LDR reset mid-read
        issue(id, 4'b0110, 1'b0, 0, 0, 1, 1, -1);   // LDR complete
        issue(id, 4'b0101, 1'b0, 0, 0, 1, 1, -1);   // AND, register form
        issue(id, 4'b1001, 1'b1, 0, 0, 1, 1, -1);   // NOT
        issue(id, 4'b1100, 1'b0, 0, 0, 1, 1, -1);   // JMP
        issue(id, 4'b1010, 1'b0, 0, 0, 1, 1, -1);   // unsupported opcode
        repeat (40) begin
            op = 4'($urandom_range(0, 15));
            ra = -1;
            if (op == 4'b0110 && $urandom_range(0, 3) == 0) ra = $urandom_range(0, w);
            issue(id, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4), ra);
        end
        checks++;
        if (exp_q[id].size() != 0) begin
            failures++;
            $display("FAIL drain cfg%0d: %0d expected words left, required 0", id, exp_q[id].size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fork
            play(0);
            play(1);
            play(2);
            play(3);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: stimulus did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
